bus_trace: RTL

- Downstream observer of the cartridge-bus responder; taps the same registered bus samples (nrd, nwr, ncs, adr, data).
- Detects each completed bus transaction and timestamps it.
- Packs each transaction into a 32-bit record, buffers records in a FIFO, and drains them as a byte stream to the serial/LED reporting stage.
- Replaces ad-hoc single-event capture (for example, "first read of address 0") with a full transaction log.

---
 rtl/bus_trace_pkg.sv | 37 +++
 rtl/bus_trace_if.sv | 27 ++
 rtl/bus_trace_fifo.sv | 47 ++++
 rtl/bus_trace.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bus_trace_pkg.sv
// Shared record layout, field widths and drain-state encoding for the bus transaction tracer.
// Records are 32 bits: {is_write, lost, adr[6:0], data[7:0], ts[14:0]}.
package bus_trace_pkg;
  localparam int REC_W    = 32;
  localparam int TS_W     = 15;
  localparam int ADR_W    = 7;
  localparam int DAT_W    = 8;
  localparam int LEN_W    = 8;
  localparam int TS_LSB   = 0;
  localparam int DAT_LSB  = TS_LSB + TS_W;
  localparam int ADR_LSB  = DAT_LSB + DAT_W;
  localparam int LOST_BIT = ADR_LSB + ADR_W;
  localparam int WR_BIT   = LOST_BIT + 1;

  typedef enum logic [2:0] {S_IDLE, S_B3, S_B2, S_B1, S_B0} drain_state_t;

  typedef struct packed {
    logic             is_write;
    logic             lost;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [TS_W-1:0]  ts;
  } rec_t;

  // Byte presented in each drain state, most significant byte first.
  function automatic logic [7:0] rec_byte(input rec_t r, input drain_state_t st);
    logic [REC_W-1:0] v;
    v = r;
    case (st)
      S_B3:    return v[31:24];
      S_B2:    return v[23:16];
      S_B1:    return v[15:8];
      S_B0:    return v[7:0];
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/bus_trace_if.sv
// Bus tap, drain stream and status bundle of the tracer; master = environment, slave = tracer.
interface bus_trace_if
  import bus_trace_pkg::*;
#(parameter int DEPTH = 16);
  logic                   nrd;
  logic                   nwr;
  logic                   ncs;
  logic [ADR_W-1:0]       adr;
  logic [DAT_W-1:0]       data;
  logic                   tick;
  logic                   enable;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;

  modport master (
    output nrd, nwr, ncs, adr, data, tick, enable, out_ready,
    input  out_data, out_valid, fifo_level, overflow
  );

  modport slave (
    input  nrd, nwr, ncs, adr, data, tick, enable, out_ready,
    output out_data, out_valid, fifo_level, overflow
  );
endinterface

// File: rtl/bus_trace_fifo.sv
// Synchronous DEPTH x W record FIFO; level is registered and follows push/pop by one cycle.
// Push on a full FIFO is ignored unless a pop frees the slot in the same cycle.
module bus_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/bus_trace.sv
// Logs every completed bus transaction as a timestamped 32-bit record and drains it as 4 bytes MSB first.
// FIFO entry 1 cycle after release, first byte 2 cycles later; out_ready low holds the byte. Option: BUS_TRACE_ADR_FILTER_EN.
module bus_trace
  import bus_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int MIN_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef BUS_TRACE_ADR_FILTER_EN
  input  logic [ADR_W-1:0] filt_adr,
  input  logic [ADR_W-1:0] filt_mask,
`endif
  bus_trace_if.slave       bus
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             active, active_q, rise, fall;
  logic [TS_W-1:0]  ts_cnt, cur_ts;
  logic [ADR_W-1:0] cur_adr;
  logic [DAT_W-1:0] cur_dat;
  logic [LEN_W-1:0] len;
  logic             cur_wr, cap, filt_hit;
  logic             push_vld, push_ok, lost_pending, overflow_q;
  logic [REC_W-1:0] push_dat, pop_dat;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [LVL_W-1:0] level;
  drain_state_t     state_q, state_d;
  rec_t             sh_q, sh_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, xfer;

  assign active = !bus.ncs && (!bus.nrd || !bus.nwr);
  assign rise   = active && !active_q;
  assign fall   = !active && active_q;

`ifdef BUS_TRACE_ADR_FILTER_EN
  assign filt_hit = ((cur_adr ^ filt_adr) & filt_mask) == '0;
`else
  assign filt_hit = 1'b1;
`endif

  // Capture: cap tracks whether enable was high from the start edge through release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      ts_cnt   <= '0;
      cur_ts   <= '0;
      cur_adr  <= '0;
      cur_dat  <= '0;
      cur_wr   <= 1'b0;
      cap      <= 1'b0;
      len      <= '0;
      push_vld <= 1'b0;
    end else begin
      active_q <= active;
      if (bus.tick) ts_cnt <= ts_cnt + 1'b1;
      if (rise) begin
        cur_adr <= bus.adr;
        cur_ts  <= ts_cnt;
        cur_wr  <= !bus.nwr;
        cur_dat <= bus.data;
        cap     <= bus.enable;
        len     <= LEN_W'(1);
      end else if (active) begin
        cur_dat <= bus.data;
        cur_wr  <= cur_wr | !bus.nwr;
        cap     <= cap & bus.enable;
        if (len != '1) len <= len + 1'b1;
      end
      push_vld <= fall && cap && bus.enable && (len >= LEN_W'(MIN_LEN)) && filt_hit;
    end
  end

  assign push_ok = !fifo_full || fifo_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_pending <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (push_vld) begin
      lost_pending <= !push_ok;
      if (!push_ok) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    push_dat                      = '0;
    push_dat[WR_BIT]              = cur_wr;
    push_dat[LOST_BIT]            = lost_pending;
    push_dat[ADR_LSB +: ADR_W]    = cur_adr;
    push_dat[DAT_LSB +: DAT_W]    = cur_dat;
    push_dat[TS_LSB +: TS_W]      = cur_ts;
  end

  bus_trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign xfer = out_valid_q && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        sh_d     = pop_dat;
        state_d  = S_B3;
      end
      S_B3: if (xfer) state_d = S_B2;
      S_B2: if (xfer) state_d = S_B1;
      S_B1: if (xfer) state_d = S_B0;
      S_B0: if (xfer) begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = pop_dat;
          state_d  = S_B3;
        end else begin
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d != S_IDLE);
    out_data_d  = rec_byte(sh_d, state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;
endmodule
